// File: rtl/unit_rr_arbiter_if.sv
// unit_rr_arbiter_if: request/response handshake bundle.
// req_*: N_REQ-wide valid/x/y in, one-hot ready out; rsp_*: id/z out, ready in.
interface unit_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_x;
  logic [N_REQ-1:0] req_y;
  logic [N_REQ-1:0] req_ready;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_z;
  logic             rsp_ready;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_z,
    output rsp_ready
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_z,
    input  rsp_ready
  );
endinterface

// File: rtl/unit_rr_arbiter.sv
// unit_rr_arbiter: round-robin sharing of one x/y->z unit among N_REQ users.
// Ports: clk, rst_n, bus (slave), unit_x/unit_y out, unit_z in, busy, grant_count.
module unit_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int UNIT_LAT = 1,
  parameter int IDW      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  unit_rr_arbiter_if.slave    bus,
  output logic                unit_x,
  output logic                unit_y,
  input  logic                unit_z,
  output logic                busy,
  output logic [7:0]          grant_count
);

  localparam int CW = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(UNIT_LAT - 1);
  localparam logic [IDW-1:0] PTR_RST = IDW'(N_REQ - 1);
  localparam logic [IDW:0] N_WIDE = (IDW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_z_q;

  logic [IDW-1:0]   win;
  logic             found;
  logic [N_REQ-1:0] ready;
  logic             accept;
  logic             sample;
  logic             rsp_done;

  // Scan ptr+1 .. ptr+N_REQ; the last step lands back on ptr itself.
  always_comb begin
    logic [IDW:0] sum;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= N_WIDE) begin
        sum = sum - N_WIDE;
      end
      if (!found && bus.req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (rst_n && state_q == IDLE && found) begin
      ready[win] = 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign accept        = (state_q == IDLE) && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sample   = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_x      <= 1'b0;
      unit_y      <= 1'b0;
      id_q        <= '0;
      ptr_q       <= PTR_RST;
      cnt_q       <= '0;
      grant_count <= '0;
    end else if (accept) begin
      unit_x      <= bus.req_x[win];
      unit_y      <= bus.req_y[win];
      id_q        <= win;
      ptr_q       <= win;
      cnt_q       <= CNT_INIT;
      grant_count <= grant_count + 8'd1;
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= 1'b0;
    end else if (sample) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_z_q     <= unit_z;
    end else if (rsp_done) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_unit_rr_arbiter.sv
// tb_unit_rr_arbiter: vector table, grant sequences and a response scoreboard.
// Shared unit modelled as registered-input AND, UNIT_LAT=1, N_REQ=4.
module tb_unit_rr_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       unit_x;
  logic       unit_y;
  logic       unit_z;
  logic       busy;
  logic [7:0] grant_count;

  unit_rr_arbiter_if #(.N_REQ(N), .IDW(IDW)) bus ();

  unit_rr_arbiter #(
    .N_REQ(N),
    .UNIT_LAT(1),
    .IDW(IDW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .unit_x(unit_x),
    .unit_y(unit_y),
    .unit_z(unit_z),
    .busy(busy),
    .grant_count(grant_count)
  );

  assign unit_z = unit_x & unit_y;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           z;
  } rsp_t;

  typedef struct {
    logic [3:0] v;
    logic [3:0] x;
    logic [3:0] y;
    int         gnt;
    logic       z;
  } vec_t;

  rsp_t sbq[$];
  int   gl[$];
  int   cl[$];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rsp_t mk(input int id, input logic z);
    rsp_t r;
    r.id = id[IDW-1:0];
    r.z  = z;
    return r;
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) begin
      if (oh[k]) r = k;
    end
    return r;
  endfunction

  // Scoreboard: pop on every response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d, expected none",
                 bus.rsp_id);
      end else begin
        rsp_t e;
        e = sbq.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_z", 32'(bus.rsp_z), 32'(e.z));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_txn(input logic [3:0] v, input logic [3:0] x,
                        input logic [3:0] y, input int gnt,
                        input logic z, input int cnt);
    logic [3:0] oh;
    oh = 4'b0001 << gnt;
    bus.req_valid = v;
    bus.req_x     = x;
    bus.req_y     = y;
    #1;
    chk("grant", 32'(bus.req_ready), 32'(oh));
    sbq.push_back(mk(gnt, z));
    tick();
    bus.req_valid = '0;
    chk("count", 32'(grant_count), 32'(cnt % 256));
    chk("busy_wait", 32'(busy), 32'd1);
    chk("rsp_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("unit_x", 32'(unit_x), 32'(x[gnt]));
    tick();
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic run_seq(input logic [3:0] v, input logic [3:0] x,
                         input logic [3:0] y, input bit drop,
                         input int ngr, input int budget);
    logic [3:0] rr;
    gl.delete();
    cl.delete();
    bus.req_valid = v;
    bus.req_x     = x;
    bus.req_y     = y;
    for (int c = 0; c < budget && gl.size() < ngr; c++) begin
      #1;
      rr = bus.req_ready;
      if (rr != 0) begin
        gl.push_back(idx_of(rr));
        cl.push_back(c);
      end
      tick();
      if (drop) bus.req_valid = bus.req_valid & ~rr;
      if (gl.size() >= ngr) bus.req_valid = '0;
    end
    chk("seq_grants", 32'(gl.size()), 32'(ngr));
    bus.req_valid = '0;
    repeat (3) tick();
  endtask

  initial begin
    tbl[0] = '{v: 4'b0100, x: 4'b0100, y: 4'b0100, gnt: 2, z: 1'b1};
    tbl[1] = '{v: 4'b1001, x: 4'b1000, y: 4'b1000, gnt: 3, z: 1'b1};
    tbl[2] = '{v: 4'b1001, x: 4'b0001, y: 4'b0000, gnt: 0, z: 1'b0};
    tbl[3] = '{v: 4'b0110, x: 4'b0010, y: 4'b0110, gnt: 1, z: 1'b1};
    tbl[4] = '{v: 4'b0011, x: 4'b0011, y: 4'b0001, gnt: 0, z: 1'b1};
    tbl[5] = '{v: 4'b1000, x: 4'b1000, y: 4'b0000, gnt: 3, z: 1'b0};

    bus.req_valid = 4'b1111;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_count", 32'(grant_count), 32'd0);
    chk("rst_unit_x", 32'(unit_x), 32'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single requests from idle, including the spec's first case.
    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].gnt, tbl[i].z, i + 1);
    end

    // All four requesting after reset.
    do_reset();
    sbq.push_back(mk(0, 1'b0));
    sbq.push_back(mk(1, 1'b1));
    sbq.push_back(mk(2, 1'b0));
    sbq.push_back(mk(3, 1'b1));
    run_seq(4'b1111, 4'b1111, 4'b1010, 1'b1, 4, 60);
    for (int k = 0; k < gl.size(); k++) begin
      chk("all_order", 32'(gl[k]), 32'(k));
      if (k > 0) chk("all_gap", 32'(cl[k] - cl[k-1]), 32'd3);
    end

    // Fairness between 0 and 2 held continuously.
    for (int k = 0; k < 8; k++) begin
      sbq.push_back((k % 2 == 0) ? mk(0, 1'b1) : mk(2, 1'b0));
    end
    run_seq(4'b0101, 4'b0101, 4'b0001, 1'b0, 8, 80);
    for (int k = 0; k < gl.size(); k++) begin
      chk("fair_order", 32'(gl[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
      if (k > 0) chk("fair_repeat", 32'(gl[k] != gl[k-1]), 32'd1);
    end

    // Response backpressure with a pending request from 3.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_x     = 4'b0010;
    bus.req_y     = 4'b0010;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'b0010);
    sbq.push_back(mk(1, 1'b1));
    tick();
    bus.req_valid = 4'b1000;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_rsp_z", 32'(bus.rsp_z), 32'd1);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_hold", 32'(bus.rsp_valid), 32'd1);
    tick();
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_drop", 32'(bus.rsp_valid), 32'd0);
    #1;
    chk("bp_next", 32'(bus.req_ready), 32'b1000);
    sbq.push_back(mk(3, 1'b0));
    tick();
    bus.req_valid = '0;
    tick();
    tick();

    // Reset one cycle into WAIT.
    bus.req_valid = 4'b0010;
    bus.req_x     = 4'b0010;
    bus.req_y     = 4'b0010;
    #1;
    chk("mw_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    rst_n = 1'b0;
    bus.req_valid = 4'b1001;
    #1;
    chk("mw_busy", 32'(busy), 32'd0);
    chk("mw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mw_unit_x", 32'(unit_x), 32'd0);
    chk("mw_unit_y", 32'(unit_y), 32'd0);
    chk("mw_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("mw_rsp_z", 32'(bus.rsp_z), 32'd0);
    chk("mw_count", 32'(grant_count), 32'd0);
    chk("mw_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) begin
      tick();
      chk("mw_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("mw_ready_rst", 32'(bus.req_ready), 32'd0);
    end
    rst_n = 1'b1;
    do_txn(4'b1001, 4'b0001, 4'b0001, 0, 1'b1, 1);

    // grant_count wrap over 256 accepts.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      do_txn(4'b0001, 4'b0001, 4'b0000, 0, 1'b0, k + 1);
    end
    chk("wrap_count", 32'(grant_count), 32'd0);

    tick();
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unit_rr_arbiter.md
# unit_rr_arbiter

Round-robin arbiter and sequencer that shares one single-bit compute unit among `N_REQ` requesters. The unit has the x/y-in, z-out shape of the team's `my_module` instances. The arbiter accepts one request at a time through a valid/ready handshake and drives the unit's x/y inputs from registers. It samples z after a fixed unit latency and returns the result, tagged with the requester index, through a second valid/ready handshake. It sits between requester logic and a single shared unit instance, in place of one instance per requester.

## Interface
- `N_REQ`, default 4: number of requesters, minimum 2.
- `UNIT_LAT`, default 1: cycles from a unit-input register update to the edge that samples `unit_z`, minimum 1.
- `IDW`, default 2: width of `rsp_id`; must equal `$clog2(N_REQ)`.
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, N_REQ: per-requester request valid.
- `req_x`, in, N_REQ: per-requester x operand.
- `req_y`, in, N_REQ: per-requester y operand.
- `req_ready`, out, N_REQ: one-hot accept; at most one bit high.
- `unit_x`, out, 1: registered x to the shared unit.
- `unit_y`, out, 1: registered y to the shared unit.
- `unit_z`, in, 1: result from the shared unit.
- `rsp_valid`, out, 1: response valid.
- `rsp_id`, out, IDW: index of the requester that owns the response.
- `rsp_z`, out, 1: captured unit result.
- `rsp_ready`, in, 1: response consumer ready.
- `busy`, out, 1: high when the state is not IDLE.
- `grant_count`, out, 8: total accepted requests; wraps 255 to 0.

## Operation
- **States:** IDLE, WAIT, RESP. State is registered.
- **IDLE:**
  - The winner is the first index `i` with `req_valid[i]`=1, scanning `ptr+1, ptr+2, …, ptr` modulo N_REQ.
  - `req_ready` is combinational: one-hot at the winner in IDLE, all zero otherwise.
  - When `req_valid[w] & req_ready[w]`, at that edge:
    - `unit_x` ← `req_x[w]`, `unit_y` ← `req_y[w]`
    - captured id ← w, `ptr` ← w
    - `grant_count` +1
    - wait counter ← UNIT_LAT−1
    - state → WAIT
- **WAIT:**
  - If the counter is nonzero, decrement it.
  - If the counter is 0, at that edge: `rsp_z` ← `unit_z`, `rsp_id` ← captured id, `rsp_valid` ← 1, state → RESP.
- **RESP:**
  - `rsp_valid`, `rsp_id` and `rsp_z` are held stable until `rsp_valid & rsp_ready`.
  - On that edge: `rsp_valid` ← 0 and state → IDLE.
- **Held values:** `unit_x` and `unit_y` hold their last values outside IDLE accepts. `rsp_id` and `rsp_z` hold after the handshake.
- **Dropped requests:** a requester may drop `req_valid` in IDLE before its handshake. It is not granted and `ptr` is unchanged.
- **Ignored inputs:** requests arriving during WAIT or RESP are not accepted (`req_ready`=0) and stay pending at the requester.
- **Reset** (any time, including mid-WAIT or mid-RESP):
  - state = IDLE, `ptr` = N_REQ−1 (so index 0 wins first), counter 0.
  - `unit_x`=0, `unit_y`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_z`=0, `grant_count`=0, `busy`=0.
  - `req_ready` is forced to all-zero while `rst_n`=0.
  - The in-flight transaction is discarded.

## Timing
- **Accept:** happens at edge E0.
- **Response latency:** `rsp_valid` rises after edge E0+UNIT_LAT.
- **Throughput with `rsp_ready` held at 1:** one transaction per UNIT_LAT+2 cycles (accept cycle, UNIT_LAT WAIT cycles, one RESP cycle). The next `req_ready` can assert in the cycle after the response handshake.
- **`busy`:** rises after E0 and falls after the response-handshake edge.
- **Combinational paths:** `req_ready` depends combinationally on `req_valid` and state only. There is no combinational path from `rsp_ready` to any output.
- **Response-side backpressure:** RESP holds indefinitely. No request is accepted until the response is taken.

## Test plan
Bench unit model: registered-input AND, `unit_z = unit_x & unit_y`, with UNIT_LAT=1 and N_REQ=4.
1. **Single request:** `req_valid`=0b0100, x=1, y=1, `rsp_ready`=1.
   - `req_ready`=0b0100 for one cycle.
   - `rsp_valid` one cycle after the accept, with `rsp_id`=2 and `rsp_z`=1.
   - `grant_count`=1.
2. **All requesting after reset:** `req_valid`=0b1111 held, each requester dropping valid after its handshake.
   - Grants in order 0, 1, 2, 3.
   - Accepts are 3 cycles apart.
   - `rsp_id` sequence is 0, 1, 2, 3.
3. **Fairness:** requesters 0 and 2 hold valid continuously for 8 transactions.
   - Grants alternate 0, 2, 0, 2, …
   - Neither requester is granted twice in a row.
4. **Backpressure:** `rsp_ready`=0 for 5 cycles during RESP.
   - `rsp_valid`, `rsp_id` and `rsp_z` are stable throughout.
   - `req_ready`=0 throughout.
   - One cycle after `rsp_ready`=1, the state returns to IDLE.
5. **Reset mid-WAIT:** assert `rst_n`=0 one cycle after an accept.
   - All outputs return to their reset values immediately.
   - No `rsp_valid` appears.
   - After release, requester 0 wins over 3 when both are valid.
6. **Counter wrap:** run 256 transactions.
   - `grant_count` reads 0 after the 256th accept.
   - Responses stay correct: x=1, y=0 gives z=0.
